// File: rtl/ring_stop_pkg.sv
// Shared ring definitions: flit layout, node addressing and message kinds
// used by every ring station and its testbench.
package ring_package;

    localparam int NODE_BITS     = 4;
    localparam int PAYLOAD_WIDTH = 22;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        RESP = 2'd1,
        INV  = 2'd2,
        ACK  = 2'd3
    } ring_kind_t;

    typedef struct packed {
        logic [NODE_BITS-1:0]     dest;
        logic [NODE_BITS-1:0]     src;
        ring_kind_t               kind;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } ring_flit_t;

    localparam int FLIT_WIDTH = $bits(ring_flit_t);

    // The destination field occupies the top NODE_BITS of a flattened flit.
    localparam int DEST_LSB = FLIT_WIDTH - NODE_BITS;

endpackage

// File: rtl/ring_stop_buffer.sv
// Synchronous circular FIFO with a show-ahead head; pointers carry an extra
// wrap bit so that full and empty are distinguishable without a counter.
module ring_stop_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == PTR_W'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which
    // entries are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr[ADDR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ring_stop.sv
// Ring station: buffers upstream traffic, ejects flits addressed to this node
// and merges local injections onto the downstream link with starvation bound.
module ring_stop
    import ring_package::*;
#(
    parameter int NODE_ID      = 1,
    parameter int BUF_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ring_in_valid,
    input  logic [FLIT_WIDTH-1:0]        ring_in_data,
    output logic                         ring_in_ready,
    output logic                         ring_out_valid,
    output logic [FLIT_WIDTH-1:0]        ring_out_data,
    input  logic                         ring_out_ready,
    input  logic                         inj_empty,
    input  logic [FLIT_WIDTH-1:0]        inj_data,
    output logic                         inj_get,
    input  logic                         ej_full,
    output logic [FLIT_WIDTH-1:0]        ej_data,
    output logic                         ej_put,
    output logic [$clog2(BUF_DEPTH):0]   buf_count
);

    localparam logic [NODE_BITS-1:0] NODE_ADDR = NODE_BITS'(NODE_ID);
    localparam int                   STARVE_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [FLIT_WIDTH-1:0] head;
    logic                  buf_full;
    logic                  buf_empty;
    logic                  push;
    logic                  pop;
    logic                  head_valid;
    logic                  head_eject;
    logic                  thru_cand;
    logic                  inj_cand;
    logic                  load_ok;
    logic                  starved;
    logic                  thru_win;
    logic                  inj_win;
    logic [STARVE_W-1:0]   starve_cnt;

    ring_stop_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (FLIT_WIDTH)
    ) u_buffer (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (ring_in_data),
        .pop       (pop),
        .head      (head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign head_valid = !buf_empty;
    assign head_eject = (head[DEST_LSB +: NODE_BITS] == NODE_ADDR);

    // Readiness ignores a same-cycle pop so the ready path stays shallow.
    assign ring_in_ready = reset && !buf_full;
    assign push          = ring_in_valid && ring_in_ready;

    // An ejecting head waits for the inbound FIFO, blocking through traffic.
    assign ej_put  = reset && head_valid && head_eject && !ej_full;
    assign ej_data = head;

    assign load_ok   = !ring_out_valid || ring_out_ready;
    assign thru_cand = head_valid && !head_eject;
    assign inj_cand  = !inj_empty;
    assign starved   = (starve_cnt == STARVE_MAX);

    always_comb begin
        thru_win = 1'b0;
        inj_win  = 1'b0;
        if (reset && load_ok) begin
            if (thru_cand && !(inj_cand && starved)) begin
                thru_win = 1'b1;
            end else if (inj_cand) begin
                inj_win = 1'b1;
            end
        end
    end

    assign inj_get = inj_win;
    assign pop     = ej_put || thru_win;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ring_out_valid <= 1'b0;
            ring_out_data  <= '0;
        end else if (thru_win) begin
            ring_out_valid <= 1'b1;
            ring_out_data  <= head;
        end else if (inj_win) begin
            ring_out_valid <= 1'b1;
            ring_out_data  <= inj_data;
        end else if (load_ok) begin
            ring_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (inj_empty || inj_win) begin
            starve_cnt <= '0;
        end else if (thru_win && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: doc/ring_stop.md
Name: ring_stop

Overview:
- Per-node ring station between the SMP node's outbound/inbound FIFOs and the inter-node ring link.
- Buffers through traffic arriving from the upstream ring neighbour.
- Ejects flits addressed to NODE_ID into the node's inbound FIFO.
- Injects flits popped from the node's outbound FIFO onto the downstream ring link, with starvation-bounded arbitration.

Parameters:
NODE_ID, 1, this node's 4-bit ring address; matches address[31:28] node numbering
BUF_DEPTH, 4, through-traffic buffer entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive lost injection arbitrations before injection is forced

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
ring_in_valid  in  1  upstream flit valid
ring_in_data  in  FLIT_WIDTH  upstream flit
ring_in_ready  out  1  buffer can accept (= !full)
ring_out_valid  out  1  downstream flit valid (registered)
ring_out_data  out  FLIT_WIDTH  downstream flit (registered)
ring_out_ready  in  1  downstream accepts
inj_empty  in  1  outbound FIFO empty
inj_data  in  FLIT_WIDTH  outbound FIFO head (show-ahead)
inj_get  out  1  pop outbound FIFO
ej_full  in  1  inbound FIFO full
ej_data  out  FLIT_WIDTH  flit to inbound FIFO
ej_put  out  1  push inbound FIFO
buf_count  out  $clog2(BUF_DEPTH)+1  occupied through-buffer entries

Behaviour:
- Reset (reset==0 at a clock edge): buffer flushed; in-flight flits discarded; ring_out_valid=0, ring_out_data=0, starve counter=0, buf_count=0. inj_get, ej_put and ring_in_ready are combinational: 0 while reset is low, then follow the rules below.
- Accept: flit written to buffer when ring_in_valid && ring_in_ready. ring_in_ready = !full only; no write-while-full even if the head pops the same cycle.
- Head classification: head.dest==NODE_ID → eject; otherwise → through.
- Eject: ej_put = head valid && eject && ej_full==0; ej_data = head (combinational); pop on ej_put.
  - ej_full holds the head (head-of-line blocking by design); the buffer fills and ring_in_ready drops.
- Output register load enable: load_ok = !ring_out_valid || ring_out_ready.
- Arbitration when load_ok:
  - Through candidate: head valid && through. Inject candidate: !inj_empty.
  - Only one candidate: it loads.
  - Both: through wins unless starve_cnt==STARVE_LIMIT, in which case inject wins.
  - Through win: pop buffer, load register. Inject win: inj_get=1 (single-cycle pulse), load inj_data.
- Starve counter:
  - +1 when inject pending and through wins.
  - Cleared to 0 when inject wins, or when inj_empty.
  - Saturates at STARVE_LIMIT.
- Hold: ring_out_valid && !ring_out_ready → ring_out_data stable; no through pop, no inj_get. Eject proceeds independently.
- Ring_out_valid drops after a transfer if nothing loads that cycle.
- Injected flit with dest==NODE_ID: sent on the ring normally; ejected when it returns.
- Latency:
  - Ring in accepted at cycle t → visible at head at t+1.
  - Ejected at t+1 (if !ej_full).
  - Through flit on ring_out at t+2 (no contention).
  - Inject popped at t → ring_out at t+1.
- Buffer is circular; pointers wrap modulo BUF_DEPTH with an extra wrap bit for the full/empty distinction. Simultaneous push and pop on a non-full buffer leaves buf_count unchanged.

Decomposition:
- Shared package ring_package:
  - NODE_BITS=4
  - PAYLOAD_WIDTH
  - ring_kind_t enum: REQ, RESP, INV, ACK
  - ring_flit_t packed struct: dest[3:0], src[3:0], kind, payload
  - FLIT_WIDTH=$bits(ring_flit_t)
- One sub-module, ring_stop_buffer: synchronous FIFO with show-ahead head, push/pop/full/empty/count, parameterised by depth and width.

Test Plan:
- Reset: hold reset=0 for 2 cycles with ring_in_valid=1 → ring_out_valid=0, ej_put=0, inj_get=0, buf_count=0; ring_in_ready=1 on the first cycle after release.
- Through (NODE_ID=1): flit dest=2, payload 0xA5 accepted at t → ring_out_valid=1 at t+2, data identical, buf_count back to 0.
- Eject with backpressure: dest=1 flit, ej_full=1 for 5 cycles, then 4 further dest=2 flits → ring_in_ready=0 once buf_count=4, no ring_out traffic; ej_full→0 gives ej_put for one cycle, then the through flits drain in order.
- Starvation: continuous dest=2 through stream, ring_out_ready=1, inj_empty=0 → inj_get fires after exactly 8 lost cycles (9th load slot), then through traffic resumes and the counter restarts at 0.
- Downstream stall: ring_out_ready=0 for 6 cycles with both sources pending → ring_out_data constant, no inj_get, buffer not popped; release → transfers resume the next cycle.
- Inject only: inj_empty=0, inj_data dest=3 at t → inj_get=1 at t, ring_out_valid=1 with that flit at t+1.
